// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath:
// FSM states, opcodes, mux selects and ALU control codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decode: maps ALUOp plus instruction fields to ALUControl.
module mc_aludec
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only selects sub for register-register ops; addi ignores it
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencing FSM for the multicycle RV32I datapath, with memory
// ready handshake, ImmSrc decode and ALU decode sub-block.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 into PC, wait for mem_ready
// DECODE   | OldPC+imm into ALUOut (branch target), dispatch on opcode
// MEMADR   | rs1+imm effective address into ALUOut
// MEMREAD  | load access at ALUOut, wait for mem_ready
// MEMWB    | write loaded data to register file, retire
// MEMWRITE | store access at ALUOut, retire on mem_ready
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | write ALUOut to register file, retire
// BEQ      | compare rs1-rs2, take ALUOut target if Zero, retire
// JAL      | jump to ALUOut, OldPC+4 into ALUOut for the link
// TRAP     | illegal opcode, absorbing until reset
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       retire,
    output logic       illegal
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] alu_op;
    logic       req_raw;
    logic       wr_raw;
    logic       irw_raw;
    logic       pcw_raw;
    logic       rw_raw;
    logic       ret_raw;
    logic       ill_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_raw   = 1'b0;
        wr_raw    = 1'b0;
        irw_raw   = 1'b0;
        pcw_raw   = 1'b0;
        rw_raw    = 1'b0;
        ret_raw   = 1'b0;
        ill_raw   = 1'b0;
        AdrSrc    = ADR_PC;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                req_raw   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                irw_raw   = mem_ready;
                pcw_raw   = mem_ready;
                if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BEQ;
                    OP_JAL:            state_nxt = S_JAL;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req_raw = 1'b1;
                AdrSrc  = ADR_ALUOUT;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rw_raw    = 1'b1;
                ret_raw   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                req_raw = 1'b1;
                wr_raw  = 1'b1;
                AdrSrc  = ADR_ALUOUT;
                ret_raw = mem_ready;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                rw_raw    = 1'b1;
                ret_raw   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                pcw_raw   = Zero;
                ret_raw   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pcw_raw   = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_TRAP: begin
                ill_raw = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Strobes are gated by rst_n so nothing writes while reset is held,
    // even though FETCH (the reset state) would otherwise request memory.
    assign mem_req  = req_raw & rst_n;
    assign MemWrite = wr_raw  & rst_n;
    assign IRWrite  = irw_raw & rst_n;
    assign PCWrite  = pcw_raw & rst_n;
    assign RegWrite = rw_raw  & rst_n;
    assign retire   = ret_raw & rst_n;
    assign illegal  = ill_raw & rst_n;

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_LOAD, OP_ITYPE: ImmSrc = IMM_I;
            OP_STORE:          ImmSrc = IMM_S;
            OP_BRANCH:         ImmSrc = IMM_B;
            OP_JAL:            ImmSrc = IMM_J;
            default:           ImmSrc = IMM_I;
        endcase
    end

    mc_aludec u_aludec (
        .alu_op      (alu_op),
        .op5         (op[5]),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle pushes the expected
// output bundle, a negedge monitor pops and compares it against the DUT.
module tb_multicycle_ctrl;

    localparam int P_FETCH    = 0;
    localparam int P_DECODE   = 1;
    localparam int P_MEMADR   = 2;
    localparam int P_MEMREAD  = 3;
    localparam int P_MEMWB    = 4;
    localparam int P_MEMWRITE = 5;
    localparam int P_EXECR    = 6;
    localparam int P_EXECI    = 7;
    localparam int P_ALUWB    = 8;
    localparam int P_BEQ      = 9;
    localparam int P_JAL      = 10;
    localparam int P_TRAP     = 11;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       retire;
    logic       illegal;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .retire     (retire),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_cyc = 0;
    int n_ret = 0;
    int n_irw = 0;
    int n_rw  = 0;

    logic [19:0] exp_q[$];
    string       tag_q[$];
    logic [19:0] outs;

    // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal,
    //  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
    assign outs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal,
                   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] model(input int ph, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic rdy, input logic z,
                                          input logic rstn);
        logic       m_req, m_wr, m_adr, m_irw, m_pcw, m_rw, m_ret, m_ill;
        logic [1:0] m_res, m_a, m_b, m_imm, m_aluop;
        logic [3:0] m_ctl;
        {m_req, m_wr, m_adr, m_irw, m_pcw, m_rw, m_ret, m_ill} = 8'b0;
        m_res = 2'b00; m_a = 2'b00; m_b = 2'b00; m_aluop = 2'b00;
        case (o)
            7'b0100011: m_imm = 2'b01;
            7'b1100011: m_imm = 2'b10;
            7'b1101111: m_imm = 2'b11;
            default:    m_imm = 2'b00;
        endcase
        case (ph)
            P_FETCH:    begin m_req = 1'b1; m_irw = rdy; m_pcw = rdy; m_b = 2'b10; m_res = 2'b10; end
            P_DECODE:   begin m_a = 2'b01; m_b = 2'b01; end
            P_MEMADR:   begin m_a = 2'b10; m_b = 2'b01; end
            P_MEMREAD:  begin m_req = 1'b1; m_adr = 1'b1; end
            P_MEMWB:    begin m_res = 2'b01; m_rw = 1'b1; m_ret = 1'b1; end
            P_MEMWRITE: begin m_req = 1'b1; m_wr = 1'b1; m_adr = 1'b1; m_ret = rdy; end
            P_EXECR:    begin m_a = 2'b10; m_b = 2'b00; m_aluop = 2'b10; end
            P_EXECI:    begin m_a = 2'b10; m_b = 2'b01; m_aluop = 2'b10; end
            P_ALUWB:    begin m_rw = 1'b1; m_ret = 1'b1; end
            P_BEQ:      begin m_a = 2'b10; m_aluop = 2'b01; m_pcw = z; m_ret = 1'b1; end
            P_JAL:      begin m_a = 2'b01; m_b = 2'b10; m_pcw = 1'b1; end
            P_TRAP:     m_ill = 1'b1;
            default:    m_ill = 1'b0;
        endcase
        if (m_aluop == 2'b01) m_ctl = 4'b0001;
        else if (m_aluop == 2'b10) begin
            case (f3)
                3'b000:  m_ctl = (o[5] && f7) ? 4'b0001 : 4'b0000;
                3'b010:  m_ctl = 4'b0101;
                3'b110:  m_ctl = 4'b0011;
                3'b111:  m_ctl = 4'b0010;
                default: m_ctl = 4'b0000;
            endcase
        end else m_ctl = 4'b0000;
        if (!rstn) {m_req, m_wr, m_adr, m_irw, m_pcw, m_rw, m_ret, m_ill} &= 8'b0010_0000;
        return {m_req, m_wr, m_adr, m_irw, m_pcw, m_rw, m_ret, m_ill, m_res, m_a, m_b, m_imm, m_ctl};
    endfunction

    always @(negedge clk) begin
        if (retire)   n_ret++;
        if (IRWrite)  n_irw++;
        if (RegWrite) n_rw++;
        if (exp_q.size() > 0) chk(tag_q.pop_front(), 32'(outs), 32'(exp_q.pop_front()));
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input string name, input int ph, input logic rdy, input logic z, input logic r);
        @(posedge clk);
        #1;
        rst_n     = r;
        mem_ready = rdy;
        Zero      = z;
        exp_q.push_back(model(ph, op, funct3, funct7b5, rdy, z, r));
        tag_q.push_back($sformatf("%s_cyc%0d", name, n_cyc));
        n_cyc++;
    endtask

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int fwait, input int mwait, input logic z);
        int ret0, irw0, rw0, exp_rw;
        op = o; funct3 = f3; funct7b5 = f7;
        ret0 = n_ret; irw0 = n_irw; rw0 = n_rw;
        exp_rw = (o == 7'b0100011 || o == 7'b1100011) ? 0 : 1;
        for (int i = 0; i < fwait; i++) cyc(name, P_FETCH, 1'b0, rbit(), 1'b1);
        cyc(name, P_FETCH, 1'b1, rbit(), 1'b1);
        cyc(name, P_DECODE, rbit(), rbit(), 1'b1);
        case (o)
            7'b0000011: begin
                cyc(name, P_MEMADR, rbit(), rbit(), 1'b1);
                for (int i = 0; i < mwait; i++) cyc(name, P_MEMREAD, 1'b0, rbit(), 1'b1);
                cyc(name, P_MEMREAD, 1'b1, rbit(), 1'b1);
                cyc(name, P_MEMWB, rbit(), rbit(), 1'b1);
            end
            7'b0100011: begin
                cyc(name, P_MEMADR, rbit(), rbit(), 1'b1);
                for (int i = 0; i < mwait; i++) cyc(name, P_MEMWRITE, 1'b0, rbit(), 1'b1);
                cyc(name, P_MEMWRITE, 1'b1, rbit(), 1'b1);
            end
            7'b0110011: begin
                cyc(name, P_EXECR, rbit(), rbit(), 1'b1);
                cyc(name, P_ALUWB, rbit(), rbit(), 1'b1);
            end
            7'b0010011: begin
                cyc(name, P_EXECI, rbit(), rbit(), 1'b1);
                cyc(name, P_ALUWB, rbit(), rbit(), 1'b1);
            end
            7'b1100011: cyc(name, P_BEQ, rbit(), z, 1'b1);
            default: begin
                cyc(name, P_JAL, rbit(), rbit(), 1'b1);
                cyc(name, P_ALUWB, rbit(), rbit(), 1'b1);
            end
        endcase
        @(negedge clk);
        #1;
        chk({name, "_retire_count"}, 32'(n_ret - ret0), 32'd1);
        chk({name, "_irwrite_count"}, 32'(n_irw - irw0), 32'd1);
        chk({name, "_regwrite_count"}, 32'(n_rw - rw0), 32'(exp_rw));
    endtask

    task automatic do_reset(input string name);
        cyc({name, "_held"}, P_FETCH, 1'b1, 1'b1, 1'b0);
        cyc({name, "_held"}, P_FETCH, 1'b1, 1'b0, 1'b0);
        cyc({name, "_release"}, P_FETCH, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int ret0, rw0;
        rst_n = 1'b0; mem_ready = 1'b0; Zero = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("reset");

        run_instr("add",  7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr("sub",  7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr("slt",  7'b0110011, 3'b010, 1'b0, 0, 0, 1'b0);
        run_instr("or",   7'b0110011, 3'b110, 1'b0, 0, 0, 1'b0);
        run_instr("and",  7'b0110011, 3'b111, 1'b0, 0, 0, 1'b0);
        run_instr("sll",  7'b0110011, 3'b001, 1'b1, 0, 0, 1'b0);
        run_instr("addi", 7'b0010011, 3'b000, 1'b1, 1, 0, 1'b0);
        run_instr("lw_wait", 7'b0000011, 3'b010, 1'b0, 2, 3, 1'b0);
        run_instr("sw_wait", 7'b0100011, 3'b010, 1'b0, 0, 1, 1'b0);
        run_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1);
        run_instr("beq_not",   7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr("jal",  7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr("lw",   7'b0000011, 3'b010, 1'b0, 0, 0, 1'b0);
        run_instr("sw",   7'b0100011, 3'b010, 1'b0, 0, 0, 1'b0);
        run_instr("ori",  7'b0010011, 3'b110, 1'b0, 0, 0, 1'b0);

        // Abort a load while it waits in MEMREAD; no write may follow.
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        ret0 = n_ret; rw0 = n_rw;
        cyc("lw_abort", P_FETCH, 1'b1, 1'b0, 1'b1);
        cyc("lw_abort", P_DECODE, 1'b0, 1'b0, 1'b1);
        cyc("lw_abort", P_MEMADR, 1'b0, 1'b0, 1'b1);
        cyc("lw_abort", P_MEMREAD, 1'b0, 1'b0, 1'b1);
        cyc("lw_abort", P_MEMREAD, 1'b0, 1'b0, 1'b1);
        do_reset("lw_abort_rst");
        cyc("lw_abort_after", P_FETCH, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("lw_abort_regwrite_count", 32'(n_rw - rw0), 32'd0);
        chk("lw_abort_retire_count", 32'(n_ret - ret0), 32'd0);
        run_instr("add_after_abort", 7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0);

        // Illegal opcode parks in TRAP regardless of mem_ready.
        op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
        ret0 = n_ret;
        cyc("trap", P_FETCH, 1'b1, 1'b0, 1'b1);
        cyc("trap", P_DECODE, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc("trap", P_TRAP, rbit(), rbit(), 1'b1);
        @(negedge clk);
        #1;
        chk("trap_retire_count", 32'(n_ret - ret0), 32'd0);
        do_reset("trap_rst");
        run_instr("add_after_trap", 7'b0110011, 3'b000, 1'b0, 1, 0, 1'b0);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
